spi_slave_reg_bank: RTL
=======================

// Module: spi_slave_reg_bank
// PURPOSE
//  Downstream stage of the SPI slave: consumes each received byte and its done strobe, decodes
//  a two-byte command protocol and drives the byte the slave shifts out on the next transfer.
//  Holds an 8-bit register bank that is writable and readable over SPI. A host-side read port
//  and a write strobe expose the bank to local logic.
// PARAMETERS
//  NUM_REGS    16     number of 8-bit registers, 1..128; valid addresses 0..NUM_REGS-1
//  DUMMY_BYTE  8'h00  tx_byte value whenever no read data is pending
// PORTS
//  clk         in   1                       system clock
//  rst_n       in   1                       asynchronous reset, active-low
//  ssn         in   1                       SPI slave select, active-low; high = frame boundary
//  rx_byte     in   8                       received byte from SPI slave
//  rx_done     in   1                       SPI slave done level; may stay high for several clk
//  tx_byte     out  8                       byte for SPI slave to transmit next
//  host_raddr  in   $clog2(NUM_REGS)        host read address
//  host_rdata  out  8                       reg[host_raddr], combinational
//  wr_stb      out  1                       1-clk pulse when an SPI write commits
//  wr_addr     out  7                       address of the committed write, valid with wr_stb
//  cmd_err     out  1                       1-clk pulse on out-of-range address
// BEHAVIOUR
//  - Byte event: falling edge of rx_done (rx_done_q & ~rx_done). rx_byte is sampled only on that cycle.
//  - Command byte = {rw, addr[6:0]}: rw=1 means read, rw=0 means write.
//  - FSM states: IDLE, CMD, WDATA, RDATA, IGNORE.
//    - IDLE -> CMD when ssn is low.
//    - CMD, on byte event with a write command: latch addr, go to WDATA.
//    - CMD, on byte event with a read command: tx_byte <= reg[addr], go to RDATA.
//    - WDATA, on byte event: reg[addr] <= rx_byte, wr_stb=1 next cycle, then go to IGNORE.
//    - RDATA, on byte event (dummy byte clocked in): tx_byte <= DUMMY_BYTE, go to IGNORE.
//    - IGNORE: further byte events have no effect until ssn goes high.
//  - ssn high from any state: next cycle state=IDLE and tx_byte=DUMMY_BYTE. A partial command is
//    dropped and no write occurs. If ssn high and a byte event occur in the same cycle, ssn wins.
//  - tx_byte changes only on byte events or on ssn high, so it is stable for the whole next byte.
//  - Out-of-range addr (>= NUM_REGS): write is discarded, read returns 8'h00, cmd_err pulses
//    one cycle after the command byte event, and the FSM still advances normally.
//  - Latency: a write is visible on host_rdata 1 clk after its byte event; read data is on
//    tx_byte 1 clk after the command byte event.
//  - Reset values: all registers 8'h00, tx_byte=DUMMY_BYTE, wr_stb=0, wr_addr=0, cmd_err=0,
//    state=IDLE, rx_done_q=0.
//  - Reset in mid-frame: everything returns to reset values. After release, the FSM waits for
//    ssn high before accepting a new command, so a half-received frame is never decoded.
// CONFIGURATION
//  SPI_REG_BANK_AUTOINC_EN defined: burst mode. WDATA and RDATA do not exit to IGNORE.
//    - Each data byte event does addr <= addr+1 (7-bit wrap), then writes or prefetches
//      reg[addr+1] to tx_byte.
//    - An out-of-range address during a burst pulses cmd_err and follows the out-of-range rules.
//  Undefined: single-byte transfers only, as described under BEHAVIOUR.
// STRUCTURE
//  - Shared package spi_pkg holds:
//    - FSM state enum encoding;
//    - CMD_RW_BIT=7 and CMD_ADDR_W=7;
//    - default DUMMY_BYTE.
//  - Natural sub-module: spi_byte_evt. It registers rx_done and ssn and outputs the
//    byte-event pulse and the frame-end pulse.
//  - The register array, FSM and tx mux stay in this module.
// TESTING
//  1 Write: ssn low, bytes 8'h03, 8'h5A -> wr_stb pulse with wr_addr=3; host_rdata(3)=8'h5A.
//  2 Read: preload reg5=8'hC3, send 8'h85 -> tx_byte=8'hC3 1 clk after byte event; after the next
//    byte event tx_byte=DUMMY_BYTE.
//  3 Abort: send 8'h02, raise ssn before the second byte -> no wr_stb, reg2 unchanged, state IDLE.
//  4 Out-of-range: NUM_REGS=16, send 8'h94 -> cmd_err pulse, tx_byte=8'h00.
//  5 Long rx_done: hold rx_done high 5 clk -> exactly one byte event, on its falling edge.
//  6 AUTOINC_EN: write 8'h0E, then 8'h11, 8'h22, 8'h33 -> reg14=8'h11, reg15=8'h22, and
//    cmd_err on the third data byte (addr 16).

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding and command-byte layout for the SPI register bank.
package spi_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_IGNORE} state_t;
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_ADDR_W = 7;
  localparam logic [7:0] DEF_DUMMY_BYTE = 8'h00;
endpackage

// File: rtl/spi_byte_evt.sv
// spi_byte_evt: byte-event pulse on the falling edge of rx_done, frame-end pulse on the rising edge of ssn.
module spi_byte_evt (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ssn,
  input  logic i_rx_done,
  output logic o_byte_evt,
  output logic o_frame_end
);
  logic r_rx_done_q, r_ssn_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rx_done_q <= 1'b0;
      r_ssn_q     <= 1'b0;
    end else begin
      r_rx_done_q <= i_rx_done;
      r_ssn_q     <= i_ssn;
    end
  assign o_byte_evt  = r_rx_done_q & ~i_rx_done;
  assign o_frame_end = i_ssn & ~r_ssn_q;
endmodule

// File: rtl/spi_slave_reg_bank.sv
// spi_slave_reg_bank: SPI two-byte command decoder and register bank.
// Define SPI_REG_BANK_AUTOINC_EN for burst transfers with auto-incrementing address.
module spi_slave_reg_bank
  import spi_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter logic [7:0] DUMMY_BYTE = DEF_DUMMY_BYTE,
  localparam int HAW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ssn,
  input  logic [7:0]            i_rx_byte,
  input  logic                  i_rx_done,
  output logic [7:0]            o_tx_byte,
  input  logic [HAW-1:0]        i_host_raddr,
  output logic [7:0]            o_host_rdata,
  output logic                  o_wr_stb,
  output logic [CMD_ADDR_W-1:0] o_wr_addr,
  output logic                  o_cmd_err
);
  state_t r_state, w_state_nx;
  logic [7:0] r_regs [NUM_REGS];
  logic [7:0] r_tx, w_tx_nx, w_rd;
  logic [CMD_ADDR_W-1:0] r_addr, w_addr_nx, w_acc_addr, r_wr_addr;
  logic r_armed, r_wr_stb, r_cmd_err, w_we, w_err, w_rng, w_byte_evt, w_frame_end;

  spi_byte_evt u_evt (
    .clk(clk), .rst_n(rst_n), .i_ssn(i_ssn), .i_rx_done(i_rx_done),
    .o_byte_evt(w_byte_evt), .o_frame_end(w_frame_end)
  );

  // Address touched by the current byte event: the command address, or the burst pointer
  assign w_acc_addr = (r_state == S_CMD) ? i_rx_byte[CMD_ADDR_W-1:0] :
                      (r_state == S_RDATA) ? r_addr + 1'b1 : r_addr;
  assign w_rng = 32'(w_acc_addr) < NUM_REGS;
  assign w_rd = w_rng ? r_regs[w_acc_addr[HAW-1:0]] : 8'h00;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_state_nx;

  // A frame only opens once ssn has been seen high since reset
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx = r_addr;
    w_tx_nx = r_tx;
    w_we = 1'b0;
    w_err = 1'b0;
    if (i_ssn) begin
      w_state_nx = S_IDLE;
      w_tx_nx = DUMMY_BYTE;
    end else if (r_state == S_IDLE) begin
      w_state_nx = r_armed ? S_CMD : S_IDLE;
    end else if (w_byte_evt) begin
      case (r_state)
        S_CMD: begin
          w_addr_nx = i_rx_byte[CMD_ADDR_W-1:0];
          w_err = ~w_rng;
          w_tx_nx = i_rx_byte[CMD_RW_BIT] ? w_rd : r_tx;
          w_state_nx = i_rx_byte[CMD_RW_BIT] ? S_RDATA : S_WDATA;
        end
        S_WDATA: begin
          w_we = w_rng;
`ifdef SPI_REG_BANK_AUTOINC_EN
          w_err = ~w_rng;
          w_addr_nx = r_addr + 1'b1;
`else
          w_state_nx = S_IGNORE;
`endif
        end
        S_RDATA: begin
`ifdef SPI_REG_BANK_AUTOINC_EN
          w_err = ~w_rng;
          w_addr_nx = r_addr + 1'b1;
          w_tx_nx = w_rd;
`else
          w_tx_nx = DUMMY_BYTE;
          w_state_nx = S_IGNORE;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
      r_addr <= '0;
      r_tx <= DUMMY_BYTE;
      r_wr_stb <= 1'b0;
      r_wr_addr <= '0;
      r_cmd_err <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      if (w_we) begin
        r_regs[r_addr[HAW-1:0]] <= i_rx_byte;
        r_wr_addr <= r_addr;
      end
      r_addr <= w_addr_nx;
      r_tx <= w_tx_nx;
      r_wr_stb <= w_we;
      r_cmd_err <= w_err;
      r_armed <= r_armed | w_frame_end;
    end

  assign o_tx_byte = r_tx;
  assign o_wr_stb = r_wr_stb;
  assign o_wr_addr = r_wr_addr;
  assign o_cmd_err = r_cmd_err;
  assign o_host_rdata = (32'(i_host_raddr) < NUM_REGS) ? r_regs[i_host_raddr] : 8'h00;
endmodule
